subtractor_4bit: RTL and testbench
==================================

Name: subtractor_4bit

Overview:
- Registered 4-bit parallel (ripple-borrow) subtractor computing A − B − Borrow_in.
- Built from a chain of 1-bit full-subtractor cells; results are registered on the clock with one-cycle latency.
- Used as a leaf arithmetic block wherever a small synchronous subtract with borrow chaining is required; borrow_in/borrow_out allow cascading to wider words.

Parameters:
- WIDTH, 4, operand and difference width in bits; only 4 is required to be verified, but RTL must be written generically.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a, b, borrow_in this cycle.
- a  input  WIDTH  minuend (unsigned).
- b  input  WIDTH  subtrahend (unsigned).
- borrow_in  input  1  borrow into bit 0 (subtracted from LSB).
- diff  output  WIDTH  registered difference, (a − b − borrow_in) mod 2^WIDTH.
- borrow_out  output  1  registered borrow out of MSB; 1 when a < b + borrow_in.
- out_valid  output  1  high for one cycle when diff/borrow_out hold a new result.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset: on a rising clk edge with rst=1, diff=0, borrow_out=0, out_valid=0. rst has priority over in_valid in the same cycle.
- Combinational core: ripple chain of WIDTH full-subtractor cells.
  - Cell i: d_i = a_i ^ b_i ^ bw_i.
  - Cell i: bw_{i+1} = (~a_i & b_i) | (~(a_i ^ b_i) & bw_i).
  - bw_0 = borrow_in; borrow_out = bw_WIDTH.
- Equivalent arithmetic: {borrow_out, diff} = two's-complement encoding of (a − b − borrow_in) in WIDTH+1 bits, with borrow_out = 1 iff the true result is negative.
- Latency: exactly 1 cycle. If in_valid=1 at edge N, then diff, borrow_out and out_valid=1 are visible after edge N.
- If in_valid=0 at an edge (and rst=0): out_valid←0; diff and borrow_out hold their previous values.
- Back-to-back in_valid: one result per cycle, full throughput. There is no backpressure.
- Wrap-around: negative results wrap modulo 2^WIDTH with borrow_out=1, e.g. 0−1−0 → diff=1111, borrow_out=1.
- Edge cases: 0−0−1 → 1111, bo=1; 15−15−0 → 0000, bo=0; 15−0−1 → 1110, bo=0; 0−15−1 → 0000, bo=1.
- Reset asserted mid-stream: the in-flight result is discarded, and out_valid is 0 on the cycle following the reset edge.
- No X propagation from unused inputs: when in_valid=0, the registers do not sample a, b or borrow_in.

Decomposition:
- Shared package sub_pkg holds:
  - localparam SUB_WIDTH = 4.
  - typedef logic [SUB_WIDTH-1:0] sub_word_t.
  - A struct {sub_word_t diff; logic borrow;} sub_result_t.
- One sub-module, full_subtractor (1-bit: a, b, bin → d, bout). It is instantiated WIDTH times via a generate loop in subtractor_4bit.
- The output register stage stays in subtractor_4bit.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and random operands → diff=0000, borrow_out=0, out_valid=0 throughout.
- Directed vectors, each with in_valid=1 and checked one cycle later:
  - a=0001 b=0001 bin=0 → diff=0000 bo=0.
  - a=1001 b=0101 bin=0 → 0100 bo=0.
  - a=1111 b=0001 bin=1 → 1101 bo=0.
  - a=0010 b=0100 bin=0 → 1110 bo=1.
  - a=1000 b=1000 bin=1 → 1111 bo=1.
- Latency/hold: a=1001 b=0101 bin=0 for one cycle, then in_valid=0 with a=0000 b=1111 → out_valid pulses for exactly one cycle; diff stays 0100 and bo stays 0 afterwards.
- Throughput: five back-to-back valid vectors → five consecutive out_valid=1 cycles, with results in order and 1-cycle delayed.
- Boundaries: 0−0−1 → 1111/1; 0−15−1 → 0000/1; 15−0−1 → 1110/0; 15−15−0 → 0000/0.
- Exhaustive: all 512 (a, b, bin) combinations checked against the golden model {bo, diff} = a − b − bin (5-bit); also assert rst mid-stream and check out_valid=0 on the next cycle.

Source files
------------

// File: rtl/sub_pkg.sv
// ============================================================================
// Module   : sub_pkg
// Purpose  : Shared width, word and result types for the subtractor slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sub_pkg;

  localparam int SUB_WIDTH = 4;

  typedef logic [SUB_WIDTH-1:0] sub_word_t;

  typedef struct packed {
    sub_word_t diff;
    logic      borrow;
  } sub_result_t;

  // Packs a WIDTH+1 bit {borrow, diff} vector into the result struct.
  function automatic sub_result_t sub_pack(input logic [SUB_WIDTH:0] bw_diff);
    sub_result_t r;
    r.diff   = bw_diff[SUB_WIDTH-1:0];
    r.borrow = bw_diff[SUB_WIDTH];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module   : full_subtractor
// Purpose  : 1-bit full subtractor cell: d = a - b - bin, with borrow out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  // Borrow when b exceeds a outright, or when a==b and a borrow arrives.
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

`default_nettype wire

// File: rtl/subtractor_4bit.sv
// ============================================================================
// Module   : subtractor_4bit
// Purpose  : Registered ripple-borrow subtractor, diff = a - b - borrow_in.
// Revision : 1.0
// ============================================================================
`default_nettype none

module subtractor_4bit
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             out_valid
);

  logic [WIDTH:0]   w_bw;
  logic [WIDTH-1:0] w_diff;

  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_valid;

  assign w_bw[0] = borrow_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor u_fs (
      .a   (a[i]),
      .b   (b[i]),
      .bin (w_bw[i]),
      .d   (w_diff[i]),
      .bout(w_bw[i+1])
    );
  end

  // Result registers only load on valid input so idle operands never leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_diff   <= w_diff;
        r_borrow <= w_bw[WIDTH];
      end
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign out_valid  = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_subtractor_4bit.sv
// ============================================================================
// Module   : tb_subtractor_4bit
// Purpose  : Self-checking bench for subtractor_4bit against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_subtractor_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       borrow_in = 1'b0;
  logic [3:0] diff;
  logic       borrow_out;
  logic       out_valid;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_diff  = '0;
  logic       exp_bo    = 1'b0;
  logic       exp_valid = 1'b0;

  subtractor_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
    .diff      (diff),
    .borrow_out(borrow_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, and check all outputs.
  task automatic cycle(input string tag, input logic rs, input logic v,
                       input logic [3:0] ta, input logic [3:0] tb_, input logic tbin);
    logic [4:0] res;
    rst = rs; in_valid = v; a = ta; b = tb_; borrow_in = tbin;
    @(posedge clk);
    #1;
    if (rs) begin
      exp_diff = '0; exp_bo = 1'b0; exp_valid = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        res = 5'(ta) - 5'(tb_) - 5'(tbin);
        exp_diff = res[3:0];
        exp_bo   = res[4];
      end
    end
    chk({tag, ".diff"},  8'(diff),       8'(exp_diff));
    chk({tag, ".bo"},    8'(borrow_out), 8'(exp_bo));
    chk({tag, ".valid"}, 8'(out_valid),  8'(exp_valid));
  endtask

  initial begin
    // Reset held with valid traffic present
    for (int i = 0; i < 2; i++)
      cycle("reset", 1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'($urandom));

    // Directed vectors
    cycle("dir0", 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    cycle("dir1", 1'b0, 1'b1, 4'b1001, 4'b0101, 1'b0);
    cycle("dir2", 1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1);
    cycle("dir3", 1'b0, 1'b1, 4'b0010, 4'b0100, 1'b0);
    cycle("dir4", 1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1);

    // Latency / hold: one valid, then idle with different operands
    cycle("hold0", 1'b0, 1'b1, 4'b1001, 4'b0101, 1'b0);
    cycle("hold1", 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0);
    cycle("hold2", 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1);
    chk("hold.diff_fixed", 8'(diff), 8'h04);
    chk("hold.bo_fixed",   8'(borrow_out), 8'h0);

    // Boundaries
    cycle("bnd0", 1'b0, 1'b1, 4'd0,  4'd0,  1'b1);
    chk("bnd0.abs", 8'({borrow_out, diff}), 8'h1F);
    cycle("bnd1", 1'b0, 1'b1, 4'd0,  4'd15, 1'b1);
    chk("bnd1.abs", 8'({borrow_out, diff}), 8'h10);
    cycle("bnd2", 1'b0, 1'b1, 4'd15, 4'd0,  1'b1);
    chk("bnd2.abs", 8'({borrow_out, diff}), 8'h0E);
    cycle("bnd3", 1'b0, 1'b1, 4'd15, 4'd15, 1'b0);
    chk("bnd3.abs", 8'({borrow_out, diff}), 8'h00);

    // Throughput: back-to-back random valid vectors
    for (int i = 0; i < 5; i++)
      cycle("thru", 1'b0, 1'b1, 4'($urandom), 4'($urandom), 1'($urandom));

    // Exhaustive operand space
    for (int i = 0; i < 512; i++)
      cycle("exh", 1'b0, 1'b1, 4'(i >> 5), 4'(i >> 1), 1'(i));

    // Random valid/idle mix
    for (int i = 0; i < 200; i++)
      cycle("rnd", 1'b0, 1'($urandom_range(0, 3) != 0),
            4'($urandom), 4'($urandom), 1'($urandom));

    // Reset mid-stream discards the in-flight result
    cycle("mid0", 1'b0, 1'b1, 4'd3, 4'd9, 1'b0);
    cycle("mid1", 1'b1, 1'b1, 4'd7, 4'd2, 1'b1);
    chk("mid1.valid_low", 8'(out_valid), 8'h0);
    cycle("mid2", 1'b0, 1'b1, 4'd7, 4'd2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
